// File: rtl/pc_sequencer.sv
//==============================================================================
// Module      : pc_sequencer
// Description : Two-phase program counter sequencer (increment, then resolve a
//               jump/branch) sharing a single 32-bit adder between both phases.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    input  logic [7:0]  OFFSET,
    output logic [31:0] PC,
    output logic [31:0] NPC,
    output logic        FETCH,
    output logic        TAKEN,
    output logic [1:0]  BUSY_STATE
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'b00,
        ST_INC     = 2'b01,
        ST_RESOLVE = 2'b10
    } state_t;

    localparam logic [31:0] c_WORD_BYTES = 32'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic        r_fetch;
    logic        r_taken;

    logic [31:0] w_pc_next;
    logic [31:0] w_npc_next;
    logic        w_fetch_next;
    logic        w_taken_next;
    logic [31:0] w_offset;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_sum;
    logic        w_take;

    // Word offset in bytes: sign-extended and scaled by 4
    assign w_offset = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign w_take   = JUMP | (BRANCH & ZERO);

    // The only adder: PC+4 while incrementing, NPC+offset while resolving
    always_comb begin
        w_op_a = r_pc;
        w_op_b = c_WORD_BYTES;
        if (r_state == ST_RESOLVE) begin
            w_op_a = r_npc;
            w_op_b = w_offset;
        end
        w_sum = w_op_a + w_op_b;
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_npc_next   = r_npc;
        w_fetch_next = 1'b0;
        w_taken_next = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_next = ST_INC;
                w_pc_next    = 32'd0;
                w_npc_next   = 32'd0;
                w_fetch_next = 1'b1;
            end
            ST_INC: begin
                if (!BUSYWAIT) begin
                    w_npc_next   = w_sum;
                    w_state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                // Control inputs only matter on this committing edge
                if (!BUSYWAIT) begin
                    w_pc_next    = w_take ? w_sum : r_npc;
                    w_taken_next = w_take;
                    w_fetch_next = 1'b1;
                    w_state_next = ST_INC;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_pc_next    = 32'd0;
                w_npc_next   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_INIT;
            r_pc    <= 32'd0;
            r_npc   <= 32'd0;
            r_fetch <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_npc   <= w_npc_next;
            r_fetch <= w_fetch_next;
            r_taken <= w_taken_next;
        end
    end

    assign PC         = r_pc;
    assign NPC        = r_npc;
    assign FETCH      = r_fetch;
    assign TAKEN      = r_taken;
    assign BUSY_STATE = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//==============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed vector table,
//               stall/reset sequences and randomized traffic against a model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [1:0] c_S_INIT = 2'b00;
    localparam logic [1:0] c_S_INC  = 2'b01;
    localparam logic [1:0] c_S_RES  = 2'b10;

    logic        clk;
    logic        rst;
    logic        busywait;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [7:0]  offset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fetch;
    logic        taken;
    logic [1:0]  busy_state;

    pc_sequencer u_dut (
        .CLK        (clk),
        .RESET      (rst),
        .BUSYWAIT   (busywait),
        .JUMP       (jump),
        .BRANCH     (branch),
        .ZERO       (zero),
        .OFFSET     (offset),
        .PC         (pc),
        .NPC        (npc),
        .FETCH      (fetch),
        .TAKEN      (taken),
        .BUSY_STATE (busy_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst, bw, j, b, z;
        logic [7:0]  off;
        logic [31:0] pc, npc;
        bit          fetch, taken;
        logic [1:0]  st;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Instruction-level model: phase 0 = idle after reset, 1 = awaiting
    // increment, 2 = awaiting resolve.
    int          m_phase = 0;
    logic [31:0] m_pc = 0, m_npc = 0;
    bit          m_fetch = 0, m_taken = 0;

    task automatic model_step(input bit r, bw, j, b, z, input logic [7:0] off);
        m_fetch = 0;
        m_taken = 0;
        if (r) begin
            m_phase = 0; m_pc = 0; m_npc = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_fetch = 1;
        end else if (m_phase == 1) begin
            if (!bw) begin m_npc = m_pc + 32'd4; m_phase = 2; end
        end else if (!bw) begin
            if (j || (b && z)) begin
                m_pc    = m_npc + 32'(int'($signed(off)) * 4);
                m_taken = 1;
            end else begin
                m_pc = m_npc;
            end
            m_fetch = 1;
            m_phase = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock, then sample just after the edge
    task automatic cyc(input bit r, bw, j, b, z, input logic [7:0] off);
        rst = r; busywait = bw; jump = j; branch = b; zero = z; offset = off;
        @(posedge clk);
        #1;
        model_step(r, bw, j, b, z, off);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc,                m_pc);
        chk({tag, ".npc"},   npc,               m_npc);
        chk({tag, ".fetch"}, {31'd0, fetch},    {31'd0, m_fetch});
        chk({tag, ".taken"}, {31'd0, taken},    {31'd0, m_taken});
        chk({tag, ".state"}, {30'd0, busy_state}, 32'(m_phase));
    endtask

    function automatic void add(bit r, bw, j, b, z, logic [7:0] off,
                                logic [31:0] p, n, bit f, t, logic [1:0] s);
        vec_t v;
        v.rst = r; v.bw = bw; v.j = j; v.b = b; v.z = z; v.off = off;
        v.pc = p; v.npc = n; v.fetch = f; v.taken = t; v.st = s;
        vq.push_back(v);
    endfunction

    initial begin
        int cnt;
        rst = 1; busywait = 0; jump = 0; branch = 0; zero = 0; offset = 0;

        // rst bw j b z off        pc           npc         f t state
        add(1, 0, 0, 0, 0, 8'h00, 32'h0,       32'h0,      0, 0, c_S_INIT);
        add(1, 1, 1, 1, 1, 8'h11, 32'h0,       32'h0,      0, 0, c_S_INIT);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h0,      1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h4,      0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'h4,       32'h4,      1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h4,       32'h8,      0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'h8,       32'h8,      1, 0, c_S_INC);
        add(0, 0, 1, 1, 1, 8'hFF, 32'h8,       32'hC,      0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'hC,       32'hC,      1, 0, c_S_INC);
        add(0, 0, 1, 0, 0, 8'h40, 32'hC,       32'h10,     0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'h10,      32'h10,     1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h10,      32'h14,     0, 0, c_S_RES);
        add(0, 0, 0, 1, 1, 8'h03, 32'h20,      32'h14,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h20,      32'h24,     0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'hFE, 32'h1C,      32'h24,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h1C,      32'h20,     0, 0, c_S_RES);
        add(0, 0, 0, 1, 0, 8'h05, 32'h20,      32'h20,     1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h20,      32'h24,     0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'h7F, 32'h220,     32'h24,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h220,     32'h224,    0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'h87, 32'h40,      32'h224,    1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h40,      32'h44,     0, 0, c_S_RES);
        add(0, 0, 0, 1, 1, 8'h03, 32'h50,      32'h44,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h50,      32'h54,     0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'hFB, 32'h40,      32'h54,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h40,      32'h44,     0, 0, c_S_RES);
        add(0, 0, 0, 1, 0, 8'h03, 32'h44,      32'h44,     1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h44,      32'h48,     0, 0, c_S_RES);
        add(0, 0, 1, 1, 0, 8'h03, 32'h54,      32'h48,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h54,      32'h58,     0, 0, c_S_RES);
        add(0, 0, 0, 0, 1, 8'h03, 32'h58,      32'h58,     1, 0, c_S_INC);
        add(1, 0, 0, 0, 0, 8'h00, 32'h0,       32'h0,      0, 0, c_S_INIT);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h0,      1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h4,      0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'hFE, 32'hFFFFFFFC, 32'h4,     1, 1, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'hFFFFFFFC, 32'h0,     0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h0,      1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h0,       32'h4,      0, 0, c_S_RES);
        add(0, 0, 0, 0, 0, 8'h00, 32'h4,       32'h4,      1, 0, c_S_INC);
        add(0, 0, 0, 0, 0, 8'h00, 32'h4,       32'h8,      0, 0, c_S_RES);
        add(0, 0, 1, 0, 0, 8'h80, 32'hFFFFFE08, 32'h8,     1, 1, c_S_INC);

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].bw, vq[i].j, vq[i].b, vq[i].z, vq[i].off);
            chk($sformatf("tbl%0d.pc", i),    pc,  vq[i].pc);
            chk($sformatf("tbl%0d.npc", i),   npc, vq[i].npc);
            chk($sformatf("tbl%0d.fetch", i), {31'd0, fetch}, {31'd0, vq[i].fetch});
            chk($sformatf("tbl%0d.taken", i), {31'd0, taken}, {31'd0, vq[i].taken});
            chk($sformatf("tbl%0d.state", i), {30'd0, busy_state}, {30'd0, vq[i].st});
        end

        // Stall: 3 cycles held in INC, advance, 2 cycles held in RESOLVE
        cyc(1, 0, 0, 0, 0, 8'h00); chk_model("st_rst");
        cyc(0, 0, 0, 0, 0, 8'h00); chk_model("st_init");
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 1, 1, 8'h10); chk_model("st_inc_hold");
        end
        cyc(0, 0, 0, 0, 0, 8'h00); chk_model("st_adv");
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 0, 0, 8'h10); chk_model("st_res_hold");
        end
        cyc(0, 0, 1, 0, 0, 8'h02); chk_model("st_commit");
        chk("st_commit_pc", pc, 32'h0C);
        chk("st_commit_taken", {31'd0, taken}, 32'd1);

        // Commit latency from a fresh fetch with the same stall pattern
        cyc(0, 1, 0, 0, 0, 8'h00); cyc(0, 1, 0, 0, 0, 8'h00); cyc(0, 1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 8'h00);
        busywait = 1;
        cnt = 4;
        for (int k = 0; k < 20 && !fetch; k++) begin
            if (k >= 2) busywait = 0;
            cyc(0, busywait, 0, 0, 0, 8'h00);
            cnt++;
        end
        chk("stall_latency_edges", 32'(cnt), 32'd7);
        chk_model("st_after");

        // Reset in RESOLVE with a pending jump drops the target
        cyc(0, 0, 0, 0, 0, 8'h00); chk_model("rr_inc");
        chk("rr_in_resolve", {30'd0, busy_state}, {30'd0, c_S_RES});
        cyc(1, 0, 1, 0, 0, 8'h10); chk_model("rr_reset");
        chk("rr_pc0", pc, 32'd0);
        chk("rr_state_init", {30'd0, busy_state}, {30'd0, c_S_INIT});
        cyc(0, 0, 1, 0, 0, 8'h10); chk_model("rr_release");
        chk("rr_no_taken", {31'd0, taken}, 32'd0);
        chk("rr_fetch", {31'd0, fetch}, 32'd1);
        chk("rr_fetch_pc", pc, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            chk_model($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
